// File: rtl/medidor_pkg.sv
// Shared types and defaults for the period meter.
package medidor_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ARMADO,
    MEDINDO
  } estado_t;

  localparam int unsigned CNT_W_PADRAO = 6;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: registers din and pulses borda for one cycle on each 0->1 transition.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic borda
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign borda = din & ~din_q;

endmodule

// File: rtl/medidor_periodo.sv
// Measures cycles between rising edges of evento, flags mismatches against periodo_esperado,
// and presents each result through a valid/ack handshake.
module medidor_periodo
  import medidor_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_PADRAO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilita,
  input  logic             evento,
  input  logic [CNT_W-1:0] periodo_esperado,
  output logic [CNT_W-1:0] periodo,
  output logic             valido,
  input  logic             ack,
  output logic             erro,
  output logic             estouro,
  output logic             perdido
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntUm  = CNT_W'(1);

  logic             borda;
  estado_t          estado_q;
  logic [CNT_W-1:0] cnt_q;
  logic             publica;
  logic             estouro_next;

  logic [CNT_W-1:0] periodo_q;
  logic             valido_q;
  logic             erro_q;
  logic             estouro_q;
  logic             perdido_q;

  detector_borda u_detector_borda (
    .clk  (clk),
    .reset(reset),
    .din  (evento),
    .borda(borda)
  );

  // A result exists only when an edge closes a period that an earlier edge opened.
  assign publica      = habilita && (estado_q == MEDINDO) && borda;
  assign estouro_next = (cnt_q == CntMax);

  // Dropping habilita wins over any edge and throws away the partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
    end else if (!habilita) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          estado_q <= ARMADO;
        end
        ARMADO: begin
          if (borda) begin
            estado_q <= MEDINDO;
            cnt_q    <= CntUm;
          end
        end
        MEDINDO: begin
          if (borda) begin
            cnt_q <= CntUm;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntUm;
          end
        end
        default: begin
          estado_q <= OCIOSO;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  // A publish in the same cycle as ack hands over the old result and loads the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      periodo_q <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      estouro_q <= 1'b0;
      perdido_q <= 1'b0;
    end else if (publica) begin
      periodo_q <= cnt_q;
      estouro_q <= estouro_next;
      erro_q    <= estouro_next | (cnt_q != periodo_esperado);
      valido_q  <= 1'b1;
      if (valido_q && !ack) begin
        perdido_q <= 1'b1;
      end
    end else if (valido_q && ack) begin
      valido_q <= 1'b0;
    end
  end

  assign periodo = periodo_q;
  assign valido  = valido_q;
  assign erro    = erro_q;
  assign estouro = estouro_q;
  assign perdido = perdido_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Scoreboard bench for medidor_periodo: a cycle-indexed edge-timestamp model feeds a queue of
// expected results, and an independent monitor checks every result the consumer accepts.
module tb_medidor_periodo;
  import medidor_pkg::*;

  localparam int unsigned W   = CNT_W_PADRAO;
  localparam int          SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         habilita = 1'b0;
  logic         evento = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] periodo_esperado = '0;
  logic [W-1:0] periodo;
  logic         valido;
  logic         erro;
  logic         estouro;
  logic         perdido;

  medidor_periodo #(.CNT_W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .habilita        (habilita),
    .evento          (evento),
    .periodo_esperado(periodo_esperado),
    .periodo         (periodo),
    .valido          (valido),
    .ack             (ack),
    .erro            (erro),
    .estouro         (estouro),
    .perdido         (perdido)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] p;
    logic         e;
    logic         o;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: timestamps of counted edges and the pending-result view.
  bit   m_val = 1'b0;
  bit   m_perdido = 1'b0;
  bit   ev_prev = 1'b0;
  bit   ok_prev = 1'b0;
  bit   last_ok = 1'b0;
  int   cyc = 0;
  int   last_t = 0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
    end
  endtask

  // Drives one clock cycle of inputs and advances the model to the state after that edge.
  task automatic step(input bit r, input bit h, input bit e, input bit a, input int esp);
    bit   borda;
    bit   conta;
    bit   publ;
    res_t res;
    int   per;
    @(negedge clk);
    reset            = r;
    habilita         = h;
    evento           = e;
    ack              = a;
    periodo_esperado = W'(esp);
    borda = e && !ev_prev;
    // An edge counts only if measuring was enabled on the previous cycle and still is.
    conta = borda && h && !r && ok_prev;
    publ  = 1'b0;
    res   = '0;
    if (conta && last_ok) begin
      per = cyc - last_t;
      if (per > SAT) per = SAT;
      res.p = W'(per);
      res.o = (per == SAT);
      res.e = res.o || (per != esp);
      publ  = 1'b1;
    end
    if (r) begin
      m_val     = 1'b0;
      m_perdido = 1'b0;
      exp_q.delete();
    end else if (publ) begin
      if (m_val && !a) begin
        exp_q.delete(exp_q.size() - 1);
        m_perdido = 1'b1;
      end
      exp_q.push_back(res);
      m_val = 1'b1;
    end else if (a && m_val) begin
      m_val = 1'b0;
    end
    if (r || !h) begin
      last_ok = 1'b0;
    end else if (conta) begin
      last_ok = 1'b1;
      last_t  = cyc;
    end
    ev_prev = r ? 1'b0 : e;
    ok_prev = h && !r;
    cyc++;
  endtask

  // amode: 0 = ack low, 1 = ack high, 2 = ack only on the pulse cycle.
  task automatic pulses(input int n, input int per, input int amode, input int esp);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < per; j++) begin
        bit e;
        e = (j == 0);
        step(1'b0, 1'b1, e, (amode == 2) ? e : (amode == 1), esp);
      end
    end
  endtask

  task automatic samp();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is consumed on any edge where valido and ack were both high.
  bit   p_val = 1'b0;
  res_t p_res = '0;
  res_t mon_x;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (p_val && ack && !reset) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL accept_empty: got result %0h expected none", p_res);
        end else begin
          mon_x = exp_q.pop_front();
          check("resultado", p_res, mon_x);
        end
      end
      check("valido", valido, m_val);
      check("perdido", perdido, m_perdido);
      p_val = valido;
      p_res = {periodo, erro, estouro};
    end
  end

  initial begin
    int dens;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    samp();
    check("rst_periodo", periodo, 0);
    check("rst_erro", erro, 0);
    check("rst_estouro", estouro, 0);

    // Period 32 matching the expectation.
    repeat (2) step(0, 1, 0, 1, 32);
    pulses(5, 32, 1, 32);
    samp();
    check("p32_periodo", periodo, 32);
    check("p32_erro", erro, 0);
    check("p32_estouro", estouro, 0);

    // Same period, wrong expectation.
    pulses(3, 32, 1, 31);
    samp();
    check("p32e31_periodo", periodo, 32);
    check("p32e31_erro", erro, 1);
    check("p32e31_estouro", estouro, 0);

    // Gap of 71 cycles saturates.
    step(0, 1, 1, 1, 31);
    repeat (70) step(0, 1, 0, 1, 31);
    step(0, 1, 1, 1, 31);
    repeat (3) step(0, 1, 0, 1, 31);
    samp();
    check("sat_periodo", periodo, SAT);
    check("sat_estouro", estouro, 1);
    check("sat_erro", erro, 1);

    // Unacked results get overwritten; perdido is sticky.
    pulses(4, 5, 0, 5);
    samp();
    check("ovw_perdido", perdido, 1);
    repeat (3) step(0, 1, 0, 0, 5);
    samp();
    check("ovw_perdido_sticky", perdido, 1);

    // Ack coinciding with publish keeps valido and does not lose anything.
    step(1, 0, 0, 0, 5);
    step(0, 1, 0, 0, 5);
    samp();
    check("rst2_perdido", perdido, 0);
    pulses(4, 5, 2, 5);
    samp();
    check("ackpub_valido", valido, 1);
    check("ackpub_perdido", perdido, 0);
    check("ackpub_periodo", periodo, 5);

    // Held-high evento is a single edge.
    step(1, 0, 0, 0, 13);
    step(0, 1, 0, 1, 13);
    repeat (10) step(0, 1, 1, 1, 13);
    repeat (3) step(0, 1, 0, 1, 13);
    step(0, 1, 1, 1, 13);
    repeat (2) step(0, 1, 0, 1, 13);
    samp();
    check("alto_periodo", periodo, 13);
    check("alto_erro", erro, 0);

    // evento already high when habilita rises is not an edge.
    step(1, 0, 0, 0, 5);
    repeat (3) step(0, 0, 1, 0, 5);
    repeat (5) step(0, 1, 1, 0, 5);
    repeat (3) step(0, 1, 0, 0, 5);
    step(0, 1, 1, 0, 5);
    repeat (2) step(0, 1, 0, 0, 5);
    samp();
    check("prehab_sem_res", valido, 0);
    repeat (2) step(0, 1, 0, 0, 5);
    step(0, 1, 1, 0, 5);
    samp();
    check("prehab_valido", valido, 1);
    check("prehab_periodo", periodo, 5);

    // Reset mid-measurement with a pending result.
    step(1, 0, 0, 0, 5);
    step(0, 1, 0, 0, 5);
    step(0, 1, 1, 0, 5);
    repeat (4) step(0, 1, 0, 0, 5);
    step(0, 1, 1, 0, 5);
    repeat (16) step(0, 1, 0, 0, 5);
    step(1, 1, 0, 0, 5);
    samp();
    check("rstmid_periodo", periodo, 0);
    check("rstmid_valido", valido, 0);
    check("rstmid_erro", erro, 0);
    check("rstmid_perdido", perdido, 0);

    // habilita drop discards the pre-drop edge.
    step(0, 1, 0, 1, 5);
    step(0, 1, 1, 1, 5);
    repeat (3) step(0, 1, 0, 1, 5);
    step(0, 0, 0, 1, 5);
    step(0, 1, 0, 1, 5);
    step(0, 1, 1, 1, 5);
    repeat (3) step(0, 1, 0, 1, 5);
    samp();
    check("habdrop_sem_res", valido, 0);

    // Randomized traffic with varying edge density.
    dens = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       dens = 1;
          1:       dens = 5;
          default: dens = 40;
        endcase
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, dens) == 0, $urandom_range(0, 2) != 0, $urandom_range(2, 8));
    end
    samp();
    check("fila_final", exp_q.size(), m_val ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
